mem_bus_arbiter: RTL

- Shares the single-port 256x8 synchronous memory between NREQ bus masters: the eightbit core plus loader/debug/DMA masters.
- Sits between the masters and the memory. Drives the memory's addr/data/we, and returns read data with a per-master valid strobe.
- Round-robin arbitration; one transfer per two clock cycles.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_if.sv | 34 +++
 rtl/mem_bus_arbiter_rr_pick.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   state_t   : arbiter FSM states
//   DEF_AW/DW : default address/data widths of the 256x8 memory
//   NREQ_MAX  : largest supported number of masters; sizes the pointer
//   rr_next   : round-robin pointer increment, wrapping at the master count
package mem_bus_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DEF_AW   = 8;
    localparam int DEF_DW   = 8;
    localparam int NREQ_MAX = 4;
    localparam int PTR_W    = $clog2(NREQ_MAX);

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int n);
        if (int'(idx) + 1 >= n)
            return '0;
        return idx + PTR_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side bus of the memory arbiter.
//   req/we_i/addr_i/wdata_i : per-master command, master i in slice i
//   gnt                     : one-hot grant, one cycle per transfer
//   rvalid/rdata            : one-hot read strobe and shared read data
//   lock                    : per-master lock request (MEM_BUS_ARBITER_LOCK_EN only)
// Modports: master (requesters / testbench), slave (arbiter).
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] wdata_i;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic [NREQ-1:0]    lock;

    modport master (output req, we_i, addr_i, wdata_i, lock,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we_i, addr_i, wdata_i, lock,
                    output gnt, rvalid, rdata);
`else
    modport master (output req, we_i, addr_i, wdata_i,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we_i, addr_i, wdata_i,
                    output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr,
// wrapping modulo NREQ.
//   req     : request vector
//   ptr     : highest-priority index this round
//   win_oh  : one-hot winner
//   win_idx : winner index
//   any     : at least one request present
module mem_bus_arbiter_rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        int j;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ)
                j = j - NREQ;
            if (!any && req[j]) begin
                any        = 1'b1;
                win_idx    = PTR_W'(j);
                win_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous memory between
// NREQ masters; one transfer every two cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave modport) : master requests, grants, read strobes and data
//   mem_addr/wdata/we   : registered memory command
//   mem_rdata           : registered memory read data, passed to bus.rdata
// Optional: define MEM_BUS_ARBITER_LOCK_EN to add per-master lock, letting
// one master hold the bus across a read-modify-write.
//
// state  | meaning
// IDLE   | arbitrate; a winner's command is registered onto the memory bus
// ACCESS | memory samples the command; requests ignored for this cycle
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_bus_arbiter_if.slave     bus,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    input  logic [DW-1:0]        mem_rdata
);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_d;
    logic [NREQ-1:0]   rvalid_d;
    logic [AW-1:0]     addr_d;
    logic [DW-1:0]     wdata_d;
    logic              we_d;

    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic              any_req;

`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic              locked_q, locked_d;
    logic [PTR_W-1:0]  lock_idx_q, lock_idx_d;

    // While locked only the owner is visible to the picker.
    assign req_eff = locked_q ? (bus.req & (NREQ'(1) << lock_idx_q)) : bus.req;
`else
    assign req_eff = bus.req;
`endif

    assign bus.rdata = mem_rdata;

    mem_bus_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req     (req_eff),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any_req)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rvalid_d = '0;
        we_d     = 1'b0;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
`ifdef MEM_BUS_ARBITER_LOCK_EN
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    gnt_d   = win_oh;
                    we_d    = bus.we_i[win_idx];
                    addr_d  = bus.addr_i[win_idx*AW +: AW];
                    wdata_d = bus.wdata_i[win_idx*DW +: DW];
`ifdef MEM_BUS_ARBITER_LOCK_EN
                    // A locking grant keeps the pointer where it is; the
                    // releasing grant advances it past the owner.
                    if (bus.lock[win_idx]) begin
                        locked_d   = 1'b1;
                        lock_idx_d = win_idx;
                    end else begin
                        locked_d = 1'b0;
                        ptr_d    = rr_next(win_idx, NREQ);
                    end
`else
                    ptr_d   = rr_next(win_idx, NREQ);
`endif
                end
            end
            ACCESS: begin
                state_d  = IDLE;
                // The grant register doubles as the read owner.
                rvalid_d = bus.gnt & {NREQ{~mem_we}};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            bus.gnt    <= '0;
            bus.rvalid <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            bus.gnt    <= gnt_d;
            bus.rvalid <= rvalid_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
`ifdef MEM_BUS_ARBITER_LOCK_EN
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

endmodule
